// File: rtl/serial_multiple_ctrl_if.sv
// Handshake bundle between the gsum accumulators (master side) and the
// serial multiply controller (slave side).
interface serial_multiple_ctrl_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 11,
    parameter int SCL_W = 3,
    parameter int NCH   = 16
);
    localparam int OUT_W = IN_W + SCL_W;
    localparam int CH_W  = $clog2(NCH);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_gsum;
    logic [IN_W-1:0]        in_fsum;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH_W-1:0]        out_chan;
    logic [LANES*OUT_W-1:0] out_wg;
    logic [LANES*OUT_W-1:0] out_wfg;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output in_valid, in_gsum, in_fsum, out_ready,
        input  in_ready, out_valid, out_chan, out_wg, out_wfg, busy, frame_done
    );

    modport slave (
        input  in_valid, in_gsum, in_fsum, out_ready,
        output in_ready, out_valid, out_chan, out_wg, out_wfg, busy, frame_done
    );
endinterface

// File: rtl/serial_multiple_ctrl.sv
// Serial multiply controller: one shared IN_W x SCL_W unsigned multiplier
// produces the LANES self-scaled (wg) and LANES fsum-scaled (wfg) products of
// a gsum word over 2*LANES cycles, then presents them with the channel index.
module serial_multiple_ctrl #(
    parameter int LANES = 4,
    parameter int IN_W  = 11,
    parameter int SCL_W = 3,
    parameter int NCH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_multiple_ctrl_if.slave bus
);
    localparam int OUT_W  = IN_W + SCL_W;
    localparam int CH_W   = $clog2(NCH);
    localparam int STEP_W = $clog2(2 * LANES);
    localparam int LANE_W = $clog2(LANES);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * LANES - 1);
    localparam logic [CH_W-1:0]   LAST_CHAN = CH_W'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                 state_q,      state_d;
    logic [STEP_W-1:0]      step_q,       step_d;
    logic [CH_W-1:0]        chan_q,       chan_d;
    logic [LANES*IN_W-1:0]  gsum_q,       gsum_d;
    logic [SCL_W-1:0]       fsum_q,       fsum_d;
    logic                   in_ready_q,   in_ready_d;
    logic                   out_valid_q,  out_valid_d;
    logic [CH_W-1:0]        out_chan_q,   out_chan_d;
    logic [LANES*OUT_W-1:0] out_wg_q,     out_wg_d;
    logic [LANES*OUT_W-1:0] out_wfg_q,    out_wfg_d;
    logic                   busy_q,       busy_d;
    logic                   frame_done_q, frame_done_d;

    logic [LANE_W-1:0]      lane_s;
    logic [IN_W-1:0]        mul_a_s;
    logic [SCL_W-1:0]       mul_b_s;
    logic [OUT_W-1:0]       prod_s;
    logic                   accept_s;
    logic                   deliver_s;
    logic                   unused_fsum_s;

    // Only the top SCL_W bits of fsum act as the scale factor.
    assign unused_fsum_s = ^bus.in_fsum[IN_W-SCL_W-1:0];

    assign accept_s  = in_ready_q & bus.in_valid;
    assign deliver_s = out_valid_q & bus.out_ready;

    // Shared multiplier: low step bits pick the lane, the top step bit picks
    // the lane's own top bits (wg pass) or the latched fsum scale (wfg pass).
    always_comb begin
        lane_s  = step_q[LANE_W-1:0];
        mul_a_s = gsum_q[int'(lane_s)*IN_W +: IN_W];
        if (step_q[STEP_W-1] == 1'b0) begin
            mul_b_s = mul_a_s[IN_W-1 -: SCL_W];
        end else begin
            mul_b_s = fsum_q;
        end
        prod_s = {{SCL_W{1'b0}}, mul_a_s} * {{IN_W{1'b0}}, mul_b_s};
    end

    // Next-state, datapath and registered-output computation for the FSM.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        chan_d       = chan_q;
        gsum_d       = gsum_q;
        fsum_d       = fsum_q;
        out_wg_d     = out_wg_q;
        out_wfg_d    = out_wfg_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    gsum_d  = bus.in_gsum;
                    fsum_d  = bus.in_fsum[IN_W-1 -: SCL_W];
                    step_d  = {STEP_W{1'b0}};
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (step_q[STEP_W-1] == 1'b0) begin
                    out_wg_d[int'(lane_s)*OUT_W +: OUT_W] = prod_s;
                end else begin
                    out_wfg_d[int'(lane_s)*OUT_W +: OUT_W] = prod_s;
                end
                if (step_q == LAST_STEP) begin
                    step_d  = {STEP_W{1'b0}};
                    state_d = ST_OUT;
                end else begin
                    step_d  = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
                end
            end
            ST_OUT: begin
                if (deliver_s) begin
                    if (chan_q == LAST_CHAN) begin
                        chan_d       = {CH_W{1'b0}};
                        frame_done_d = 1'b1;
                    end else begin
                        chan_d       = chan_q + {{(CH_W-1){1'b0}}, 1'b1};
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags follow the state being entered so they line up
        // with the registered state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_OUT) begin
            out_chan_d = chan_q;
        end else begin
            out_chan_d = out_chan_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= {STEP_W{1'b0}};
            chan_q       <= {CH_W{1'b0}};
            gsum_q       <= {(LANES*IN_W){1'b0}};
            fsum_q       <= {SCL_W{1'b0}};
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= {CH_W{1'b0}};
            out_wg_q     <= {(LANES*OUT_W){1'b0}};
            out_wfg_q    <= {(LANES*OUT_W){1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            chan_q       <= chan_d;
            gsum_q       <= gsum_d;
            fsum_q       <= fsum_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_chan_q   <= out_chan_d;
            out_wg_q     <= out_wg_d;
            out_wfg_q    <= out_wfg_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_chan   = out_chan_q;
    assign bus.out_wg     = out_wg_q;
    assign bus.out_wfg    = out_wfg_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_serial_multiple_ctrl.sv
// Scoreboard bench for serial_multiple_ctrl: expected products are pushed when
// a beat is accepted and checked by a monitor when the result is handed off.
module tb_serial_multiple_ctrl;
    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   fd_expect_cyc;
    int   fd_pulses;
    logic [3:0] exp_chan;

    typedef struct {
        logic [3:0]  chan;
        logic [55:0] wg;
        logic [55:0] wfg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    serial_multiple_ctrl_if bus ();

    serial_multiple_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [55:0] model_wg(input logic [43:0] g);
        logic [55:0] r;
        int a;
        r = 56'd0;
        for (int k = 0; k < 4; k++) begin
            a = int'(g[11*k +: 11]);
            r[14*k +: 14] = 14'(a * (a / 256));
        end
        return r;
    endfunction

    function automatic logic [55:0] model_wfg(input logic [43:0] g, input logic [10:0] f);
        logic [55:0] r;
        int a;
        int s;
        r = 56'd0;
        s = int'(f) / 256;
        for (int k = 0; k < 4; k++) begin
            a = int'(g[11*k +: 11]);
            r[14*k +: 14] = 14'(a * s);
        end
        return r;
    endfunction

    function automatic logic [43:0] rand_gsum();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[43:0];
    endfunction

    // Result monitor: frame_done timing and scoreboard pop on each handoff.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0) begin
            vectors++;
            if (bus.frame_done !== (cyc == fd_expect_cyc)) begin
                miscompares++;
                $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, bus.frame_done, (cyc == fd_expect_cyc));
            end
            if (bus.frame_done === 1'b1) fd_pulses++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result chan=%0d wg=%h wfg=%h", bus.out_chan, bus.out_wg, bus.out_wfg);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.out_chan !== mon_e.chan || bus.out_wg !== mon_e.wg || bus.out_wfg !== mon_e.wfg) begin
                        miscompares++;
                        $display("FAIL result got chan=%0d wg=%h wfg=%h want chan=%0d wg=%h wfg=%h",
                                 bus.out_chan, bus.out_wg, bus.out_wfg, mon_e.chan, mon_e.wg, mon_e.wfg);
                    end
                    if (mon_e.chan == 4'd15) fd_expect_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_chan = 4'd0;
        fd_expect_cyc = -1;
    endtask

    // Presents one beat, waits (bounded) for acceptance, pushes the expectation.
    task automatic send_beat(input logic [43:0] g, input logic [10:0] f, output int acc_cyc);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_gsum  = g;
        bus.in_fsum  = f;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout in_ready=%b want=1", bus.in_ready);
        end else begin
            sb.push_back('{exp_chan, model_wg(g), model_wfg(g, f)});
            exp_chan = exp_chan + 4'd1;
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gsum   = 44'hABC_DEF0_1234;
        bus.in_fsum   = 11'h7FF;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got rdy=%b vld=%b busy=%b fd=%b want 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.frame_done);
        end
        vectors++;
        if (bus.out_chan !== 4'd0 || bus.out_wg !== 56'd0 || bus.out_wfg !== 56'd0) begin
            miscompares++;
            $display("FAIL reset_data got chan=%0d wg=%h wfg=%h want 0", bus.out_chan, bus.out_wg, bus.out_wfg);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        exp_chan = 4'd0;
        fd_expect_cyc = -1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_max_values();
        int acc;
        int i;
        send_beat({4{11'h7FF}}, 11'h100, acc);
        for (i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (cyc != acc + 9) begin
            miscompares++;
            $display("FAIL max_latency got=%0d want=%0d", cyc - acc, 9);
        end
        vectors++;
        if (bus.out_wg !== {4{14'h37F9}} || bus.out_wfg !== {4{14'h07FF}} || bus.out_chan !== 4'd0) begin
            miscompares++;
            $display("FAIL max_values got wg=%h wfg=%h chan=%0d want wg=%h wfg=%h chan=0",
                     bus.out_wg, bus.out_wfg, bus.out_chan, {4{14'h37F9}}, {4{14'h07FF}});
        end
        wait_drain();
    endtask

    task automatic test_mixed_lanes();
        int acc;
        send_beat({11'h000, 11'h100, 11'h2AB, 11'h5FF}, 11'h7FF, acc);
        wait_drain();
        send_beat(rand_gsum(), 11'($urandom), acc);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int acc;
        logic [55:0] cap_wg;
        logic [55:0] cap_wfg;
        logic [3:0]  cap_chan;
        bus.out_ready = 1'b0;
        send_beat(rand_gsum(), 11'($urandom), acc);
        for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        cap_wg = bus.out_wg;
        cap_wfg = bus.out_wfg;
        cap_chan = bus.out_chan;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_wg !== cap_wg ||
                bus.out_wfg !== cap_wfg || bus.out_chan !== cap_chan) begin
                miscompares++;
                $display("FAIL backpressure_hold cycle=%0d vld=%b rdy=%b wg=%h wfg=%h chan=%0d want vld=1 rdy=0 wg=%h wfg=%h chan=%0d",
                         i, bus.out_valid, bus.in_ready, bus.out_wg, bus.out_wfg, bus.out_chan, cap_wg, cap_wfg, cap_chan);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        wait_drain();
    endtask

    task automatic test_frame_wrap();
        int acc;
        int prev;
        do_reset(2);
        fd_pulses = 0;
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            send_beat(rand_gsum(), 11'($urandom), acc);
            if (i > 0) begin
                vectors++;
                if (acc - prev != 10) begin
                    miscompares++;
                    $display("FAIL accept_spacing beat=%0d got=%0d want=10", i, acc - prev);
                end
            end
            prev = acc;
        end
        wait_drain();
        vectors++;
        if (fd_pulses != 1) begin
            miscompares++;
            $display("FAIL frame_done_count got=%0d want=1", fd_pulses);
        end
    endtask

    task automatic test_reset_mid_op();
        int acc;
        do_reset(2);
        fd_pulses = 0;
        for (int i = 0; i < 5; i++) send_beat(rand_gsum(), 11'($urandom), acc);
        wait_drain();
        send_beat(rand_gsum(), 11'($urandom), acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_chan = 4'd0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_chan !== 4'd0 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset got busy=%b vld=%b chan=%0d fd=%b want 0 0 0 0",
                     bus.busy, bus.out_valid, bus.out_chan, bus.frame_done);
        end
        send_beat(rand_gsum(), 11'($urandom), acc);
        wait_drain();
        vectors++;
        if (fd_pulses != 0) begin
            miscompares++;
            $display("FAIL midop_frame_done got=%0d want=0", fd_pulses);
        end
    endtask

    task automatic test_input_ignored_while_busy();
        int acc;
        send_beat(44'h123_4567_89AB, 11'h5A5, acc);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = i[0];
            bus.in_gsum  = rand_gsum();
            bus.in_fsum  = 11'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || cyc != acc + 9) begin
            miscompares++;
            $display("FAIL busy_ignore_timing got vld=%b at=%0d want vld=1 at=9", bus.out_valid, cyc - acc);
        end
        wait_drain();
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_extra got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        vectors = 0;
        miscompares = 0;
        fd_pulses = 0;
        fd_expect_cyc = -1;
        exp_chan = 4'd0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_gsum   = 44'd0;
        bus.in_fsum   = 11'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_max_values();
        test_mixed_lanes();
        test_backpressure();
        test_frame_wrap();
        test_reset_mid_op();
        test_input_ignored_while_busy();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
